// File: rtl/id_decode_pipe.sv
// ID stage: decodes the instruction, drives the int/FP register-file read addresses and loads the
// ID/EX register. Handles the valid/ready handshake, EX back-pressure, flush and the load-use interlock.
module id_decode_pipe #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int FP_EN  = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [31:0]       instr,
  input  logic [31:0]       pc,
  input  logic              flush,
  input  logic              ex_ready,
  output logic [REG_AW-1:0] rs_addr,
  output logic [REG_AW-1:0] rt_addr,
  output logic [REG_AW-1:0] fp_rs_addr,
  output logic [REG_AW-1:0] fp_rt_addr,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [DATA_W-1:0] fp_rs_data,
  input  logic [DATA_W-1:0] fp_rt_data,
  output logic              dx_valid,
  output logic [6:0]        dx_ctrl,
  output logic [3:0]        dx_alu_ctrl,
  output logic [DATA_W-1:0] dx_src1,
  output logic [DATA_W-1:0] dx_src2,
  output logic [DATA_W-1:0] dx_src1_fp,
  output logic [DATA_W-1:0] dx_src2_fp,
  output logic [DATA_W-1:0] dx_mem_data,
  output logic [DATA_W-1:0] dx_mem_data_fp,
  output logic [DATA_W-1:0] dx_imm,
  output logic [REG_AW-1:0] dx_rd,
  output logic [31:0]       dx_pc,
  output logic [31:0]       dx_jump_addr,
  output logic              dx_illegal
);

  logic [5:0]               w_op;
  logic [5:0]               w_funct;
  logic [REG_AW-1:0]        w_rs_f;
  logic [REG_AW-1:0]        w_rt_f;
  logic [REG_AW-1:0]        w_rd_f;
  logic [REG_AW-1:0]        w_fd_f;
  logic                     w_legal;
  logic [3:0]               w_alu;
  logic [REG_AW-1:0]        w_rd;
  logic                     w_fp_op;
  logic                     w_mem_to_reg;
  logic                     w_reg_write;
  logic                     w_mem_read;
  logic                     w_mem_write;
  logic                     w_branch;
  logic                     w_jump;
  logic                     w_use_rs;
  logic                     w_use_rt;
  logic                     w_use_fs;
  logic                     w_use_ft;
  logic                     w_use_imm;
  logic                     w_fp_mem;
  logic [6:0]               w_ctrl;
  logic signed [DATA_W-1:0] w_imm;
  logic                     w_int_hit;
  logic                     w_fp_hit;
  logic                     w_hazard;
  logic                     w_load_en;
  logic                     w_xfer;
  logic                     w_cap;

  logic                     r_vld_p1;
  logic [6:0]               r_ctrl_p1;
  logic [3:0]               r_alu_p1;
  logic [DATA_W-1:0]        r_src1_p1;
  logic [DATA_W-1:0]        r_src2_p1;
  logic [DATA_W-1:0]        r_src1_fp_p1;
  logic [DATA_W-1:0]        r_src2_fp_p1;
  logic [DATA_W-1:0]        r_mem_data_p1;
  logic [DATA_W-1:0]        r_mem_data_fp_p1;
  logic signed [DATA_W-1:0] r_imm_p1;
  logic [REG_AW-1:0]        r_rd_p1;
  logic [31:0]              r_pc_p1;
  logic [31:0]              r_jump_addr_p1;
  logic                     r_illegal_p1;

  assign w_op    = instr[31:26];
  assign w_funct = instr[5:0];
  assign w_rs_f  = REG_AW'(instr[25:21]);
  assign w_rt_f  = REG_AW'(instr[20:16]);
  assign w_rd_f  = REG_AW'(instr[15:11]);
  assign w_fd_f  = REG_AW'(instr[10:6]);
  assign w_imm   = {{(DATA_W-16){instr[15]}}, instr[15:0]};

  // FP memory ops take their base from the int file, so the FP rs port falls back to fs otherwise.
  assign rs_addr    = w_rs_f;
  assign rt_addr    = w_rt_f;
  assign fp_rs_addr = ((w_op == 6'd49) || (w_op == 6'd57)) ? w_rs_f : w_rd_f;
  assign fp_rt_addr = w_rt_f;

  always_comb begin
    w_legal      = 1'b0;
    w_alu        = 4'd0;
    w_rd         = w_rt_f;
    w_fp_op      = 1'b0;
    w_mem_to_reg = 1'b0;
    w_reg_write  = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_branch     = 1'b0;
    w_jump       = 1'b0;
    w_use_rs     = 1'b0;
    w_use_rt     = 1'b0;
    w_use_fs     = 1'b0;
    w_use_ft     = 1'b0;
    w_use_imm    = 1'b0;
    w_fp_mem     = 1'b0;
    case (w_op)
      6'd0: begin
        w_rd        = w_rd_f;
        w_reg_write = 1'b1;
        w_use_rs    = 1'b1;
        w_use_rt    = 1'b1;
        w_legal     = 1'b1;
        case (w_funct)
          6'd36:   w_alu = 4'd0;
          6'd37:   w_alu = 4'd1;
          6'd32:   w_alu = 4'd2;
          6'd34:   w_alu = 4'd6;
          6'd42:   w_alu = 4'd7;
          default: w_legal = 1'b0;
        endcase
      end
      6'd8: begin
        w_legal = 1'b1; w_alu = 4'd2; w_reg_write = 1'b1; w_use_rs = 1'b1; w_use_imm = 1'b1;
      end
      6'd35: begin
        w_legal = 1'b1; w_alu = 4'd2; w_reg_write = 1'b1; w_mem_read = 1'b1; w_mem_to_reg = 1'b1;
        w_use_rs = 1'b1; w_use_imm = 1'b1;
      end
      6'd43: begin
        w_legal = 1'b1; w_alu = 4'd2; w_mem_write = 1'b1; w_use_rs = 1'b1; w_use_rt = 1'b1;
        w_use_imm = 1'b1;
      end
      6'd4, 6'd5: begin
        w_legal = 1'b1; w_alu = 4'd5; w_branch = 1'b1; w_use_rs = 1'b1; w_use_rt = 1'b1;
      end
      6'd2: begin
        w_legal = 1'b1; w_jump = 1'b1; w_use_rs = 1'b1;
      end
      6'd49: if (FP_EN != 0) begin
        w_legal = 1'b1; w_alu = 4'd8; w_fp_op = 1'b1; w_fp_mem = 1'b1; w_reg_write = 1'b1;
        w_mem_read = 1'b1; w_mem_to_reg = 1'b1; w_use_imm = 1'b1;
      end
      6'd57: if (FP_EN != 0) begin
        w_legal = 1'b1; w_alu = 4'd8; w_fp_op = 1'b1; w_fp_mem = 1'b1; w_mem_write = 1'b1;
        w_use_ft = 1'b1; w_use_imm = 1'b1;
      end
      6'd17: if (FP_EN != 0) begin
        w_fp_op = 1'b1; w_reg_write = 1'b1; w_rd = w_fd_f; w_use_fs = 1'b1; w_use_ft = 1'b1;
        w_legal = 1'b1;
        case (w_funct)
          6'd0:    w_alu = 4'd9;
          6'd2:    w_alu = 4'd10;
          default: w_legal = 1'b0;
        endcase
      end
      default: ;
    endcase
    // Int r0 is hardwired to zero; FP f0 is a real register.
    if (!w_fp_op && (w_rd == '0)) w_reg_write = 1'b0;
  end

  assign w_ctrl = {w_fp_op, w_mem_to_reg, w_reg_write, w_mem_read, w_mem_write, w_branch, w_jump};

  // Load-use interlock against the instruction currently held in ID/EX.
  assign w_int_hit = !r_ctrl_p1[6] && (r_rd_p1 != '0) &&
                     ((w_use_rs && (w_rs_f == r_rd_p1)) || (w_use_rt && (w_rt_f == r_rd_p1)));
  assign w_fp_hit  = r_ctrl_p1[6] &&
                     ((w_use_fs && (w_rd_f == r_rd_p1)) || (w_use_ft && (w_rt_f == r_rd_p1)));
  assign w_hazard  = r_vld_p1 && r_ctrl_p1[3] && w_legal && (w_int_hit || w_fp_hit);

  assign w_load_en = !r_vld_p1 || ex_ready;
  assign if_ready  = flush || (w_load_en && !w_hazard);
  assign w_xfer    = if_valid && if_ready;
  assign w_cap     = !flush && w_xfer && w_legal;

  // ID/EX register boundary
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_vld_p1         <= 1'b0;
      r_ctrl_p1        <= '0;
      r_alu_p1         <= '0;
      r_src1_p1        <= '0;
      r_src2_p1        <= '0;
      r_src1_fp_p1     <= '0;
      r_src2_fp_p1     <= '0;
      r_mem_data_p1    <= '0;
      r_mem_data_fp_p1 <= '0;
      r_imm_p1         <= '0;
      r_rd_p1          <= '0;
      r_pc_p1          <= '0;
      r_jump_addr_p1   <= '0;
      r_illegal_p1     <= 1'b0;
    end else if (flush || w_load_en) begin
      r_vld_p1         <= w_cap;
      r_illegal_p1     <= !flush && w_xfer && !w_legal;
      r_ctrl_p1        <= w_cap ? w_ctrl : '0;
      r_alu_p1         <= w_cap ? w_alu : '0;
      r_src1_p1        <= w_cap ? rs_data : '0;
      r_src2_p1        <= w_cap ? (w_use_imm ? w_imm : rt_data) : '0;
      r_src1_fp_p1     <= w_cap ? (w_fp_mem ? rs_data : fp_rs_data) : '0;
      r_src2_fp_p1     <= w_cap ? fp_rt_data : '0;
      r_mem_data_p1    <= w_cap ? rt_data : '0;
      r_mem_data_fp_p1 <= w_cap ? fp_rt_data : '0;
      r_imm_p1         <= w_cap ? w_imm : '0;
      r_rd_p1          <= w_cap ? w_rd : '0;
      r_pc_p1          <= w_cap ? pc : '0;
      r_jump_addr_p1   <= w_cap ? {pc[31:28], instr[25:0], 2'b00} : '0;
    end
  end

  assign dx_valid       = r_vld_p1;
  assign dx_ctrl        = r_ctrl_p1;
  assign dx_alu_ctrl    = r_alu_p1;
  assign dx_src1        = r_src1_p1;
  assign dx_src2        = r_src2_p1;
  assign dx_src1_fp     = r_src1_fp_p1;
  assign dx_src2_fp     = r_src2_fp_p1;
  assign dx_mem_data    = r_mem_data_p1;
  assign dx_mem_data_fp = r_mem_data_fp_p1;
  assign dx_imm         = r_imm_p1;
  assign dx_rd          = r_rd_p1;
  assign dx_pc          = r_pc_p1;
  assign dx_jump_addr   = r_jump_addr_p1;
  assign dx_illegal     = r_illegal_p1;

endmodule
